// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared widths and pointer helpers for the RAM FIFO controller.
package ram_fifo_pkg;
    localparam int unsigned DEF_MEM_SIZE = 6;
    localparam int unsigned DEF_DATA_W   = 10;
    localparam int unsigned DEF_AF_LEVEL = 5;
    localparam int unsigned DEF_ADDR_W   = $clog2(DEF_MEM_SIZE);
    localparam int unsigned DEF_OCC_W    = $clog2(DEF_MEM_SIZE + 2);

    function automatic int unsigned addr_width(input int unsigned size);
        return $clog2(size);
    endfunction

    // Occupancy spans 0..size+1 (RAM words plus the RAM output register).
    function automatic int unsigned occ_width(input int unsigned size);
        return $clog2(size + 2);
    endfunction

    // Increment with wrap at size-1, so any depth works, not only powers of 2.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned size);
        return (ptr == size - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/ram_fifo_ctrl_ptr_counter.sv
// mod_ptr_counter: enabled modulo-SIZE address pointer with synchronous reset to 0.
module mod_ptr_counter
    import ram_fifo_pkg::*;
#(
    parameter int unsigned SIZE = DEF_MEM_SIZE,
    parameter int unsigned W    = addr_width(SIZE)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_q, ptr_d;

    // Advance on enable, wrapping after SIZE-1.
    always_comb ptr_d = en ? W'(ptr_next(32'(ptr_q), SIZE)) : ptr_q;

    // Pointer register.
    always_ff @(posedge clock) ptr_q <= reset ? '0 : ptr_d;

    assign ptr = ptr_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller around a registered-read dual-port RAM,
// presenting RAM dataout as a first-word-fall-through stream.
// Define FIFO_ALMOST_FULL_EN to get a registered almost_full flag; otherwise it is 0.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned MEM_SIZE = DEF_MEM_SIZE,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    localparam int unsigned AW      = addr_width(MEM_SIZE),
    localparam int unsigned OW      = occ_width(MEM_SIZE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_datain,
    output logic [AW-1:0]     ram_addr_w,
    output logic              ram_read,
    output logic [AW-1:0]     ram_addr_r,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic [OW-1:0]     occ,
    output logic              almost_full
);
    localparam logic [OW-1:0] FULL_CNT = OW'(MEM_SIZE);
`ifdef FIFO_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic [OW-1:0] cnt_q, cnt_d, occ_d;
    logic          out_valid_q, out_valid_d;
    logic          af_q, af_d;
    logic [AW-1:0] wr_ptr, rd_ptr;

    mod_ptr_counter #(.SIZE(MEM_SIZE), .W(AW)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .en    (ram_write),
        .ptr   (wr_ptr)
    );

    mod_ptr_counter #(.SIZE(MEM_SIZE), .W(AW)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .en    (ram_read),
        .ptr   (rd_ptr)
    );

    assign in_ready    = cnt_q < FULL_CNT;
    assign ram_write   = in_valid & in_ready;
    assign ram_datain  = in_data;
    assign ram_addr_w  = wr_ptr;
    // A read refills the output register whenever it is empty or being drained; while
    // stalled no read is issued, so the RAM holds dataout and out_data stays stable.
    assign ram_read    = (cnt_q != '0) & (~out_valid_q | out_ready);
    assign ram_addr_r  = rd_ptr;
    assign out_valid   = out_valid_q;
    assign out_data    = ram_dataout;
    assign occ         = cnt_q + OW'(out_valid_q);
    assign almost_full = AF_EN & af_q;

    // Next RAM word count, output-register validity and almost-full flag.
    always_comb begin
        cnt_d       = cnt_q + OW'(ram_write) - OW'(ram_read);
        out_valid_d = ram_read ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        occ_d       = cnt_d + OW'(out_valid_d);
        af_d        = AF_EN && (32'(occ_d) >= AF_LEVEL);
    end

    // State registers; reset discards all held words.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench with a RAM model and a queue-based reference.
module tb_ram_fifo_ctrl;
    localparam int M  = 6;
    localparam int DW = 10;
    localparam int AW = $clog2(M);
    localparam int OW = $clog2(M + 2);

    logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid, ram_write, ram_read, almost_full;
    logic [DW-1:0] out_data, ram_datain, ram_dataout;
    logic [AW-1:0] ram_addr_w, ram_addr_r;
    logic [OW-1:0] occ;

    ram_fifo_ctrl #(.MEM_SIZE(M), .DATA_W(DW), .AF_LEVEL(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_write(ram_write), .ram_datain(ram_datain), .ram_addr_w(ram_addr_w),
        .ram_read(ram_read), .ram_addr_r(ram_addr_r), .ram_dataout(ram_dataout),
        .occ(occ), .almost_full(almost_full)
    );

    always #5 clock = ~clock;

    // Dual-port RAM with registered read and no reset.
    logic [DW-1:0] mem [M];
    always @(posedge clock) begin
        if (ram_write) mem[ram_addr_w] <= ram_datain;
        if (ram_read) ram_dataout <= mem[ram_addr_r];
    end

    int checks = 0, failures = 0;

    // Reference: words in RAM as a queue, plus the output register.
    logic [DW-1:0] mq[$];
    bit mov = 0;
    logic [DW-1:0] mod;
    int wcnt = 0, rcnt = 0;

    // Outputs observed just after the inputs of the latest step were applied.
    bit s_rdy, s_ov, s_wr, s_rd;
    logic [DW-1:0] s_od;
    int s_occ, s_aw, s_ar;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit e_rdy, e_wr, e_rd;
        @(negedge clock);
        reset = rst; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        s_rdy = in_ready; s_ov = out_valid; s_od = out_data; s_occ = int'(occ);
        s_wr = ram_write; s_rd = ram_read; s_aw = int'(ram_addr_w); s_ar = int'(ram_addr_r);
        e_rdy = mq.size() < M;
        e_wr = iv && e_rdy;
        e_rd = mq.size() != 0 && (!mov || ordy);
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("out_valid", 32'(out_valid), 32'(mov));
            chk("occ", 32'(occ), 32'(mq.size() + int'(mov)));
            chk("ram_write", 32'(ram_write), 32'(e_wr));
            chk("ram_read", 32'(ram_read), 32'(e_rd));
            chk("almost_full", 32'(almost_full), 32'(0));
            if (mov) chk("out_data", 32'(out_data), 32'(mod));
            if (e_wr) chk("ram_addr_w", 32'(ram_addr_w), 32'(wcnt % M));
            if (e_wr) chk("ram_datain", 32'(ram_datain), 32'(d));
            if (e_rd) chk("ram_addr_r", 32'(ram_addr_r), 32'(rcnt % M));
        end
        @(posedge clock);
        if (rst) begin
            mq.delete(); mov = 0; wcnt = 0; rcnt = 0;
        end else begin
            if (e_rd) begin mov = 1; mod = mq.pop_front(); rcnt++; end
            else if (ordy) mov = 0;
            if (e_wr) begin mq.push_back(d); wcnt++; end
        end
    endtask

    typedef struct {
        bit iv; logic [DW-1:0] d; bit ordy;
        bit e_rdy; bit e_ov; logic [DW-1:0] e_od; int e_occ; bit e_wr; bit e_rd; int e_addr;
    } vec_t;
    vec_t tbl[4];

    logic [DW-1:0] sent[$], got[$];
    logic [DW-1:0] held;

    initial begin
        tbl[0] = '{1, 10'h155, 1, 1, 0, 10'h000, 0, 1, 0, 0};
        tbl[1] = '{0, 10'h000, 1, 1, 0, 10'h000, 1, 0, 1, 0};
        tbl[2] = '{0, 10'h000, 1, 1, 1, 10'h155, 1, 0, 0, 0};
        tbl[3] = '{0, 10'h000, 1, 1, 0, 10'h000, 0, 0, 0, 0};

        // Reset then idle.
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0, 1);
            if (i == 0) begin
                chk("rst_occ", 32'(s_occ), 0);
                chk("rst_in_ready", 32'(s_rdy), 1);
                chk("rst_out_valid", 32'(s_ov), 0);
            end
        end

        // Single word through an empty FIFO (pointers are at 0 after reset).
        for (int i = 0; i < 4; i++) begin
            step(0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_occ", i), 32'(s_occ), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_ram_write", i), 32'(s_wr), 32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_ram_read", i), 32'(s_rd), 32'(tbl[i].e_rd));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(s_od), 32'(tbl[i].e_od));
            if (tbl[i].e_wr) chk($sformatf("tbl%0d_addr_w", i), 32'(s_aw), 32'(tbl[i].e_addr));
            if (tbl[i].e_rd) chk($sformatf("tbl%0d_addr_r", i), 32'(s_ar), 32'(tbl[i].e_addr));
        end

        // Fill to capacity with the output stalled, then drain in order.
        for (int k = 1; k <= 8; k++) step(0, 1, DW'(k), 0);
        chk("full_occ", 32'(s_occ), 7);
        chk("full_in_ready", 32'(s_rdy), 0);
        chk("full_no_write", 32'(s_wr), 0);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0, 1);
            if (s_ov) got.push_back(s_od);
        end
        chk("drain_count", 32'(got.size()), 7);
        for (int i = 0; i < got.size() && i < 7; i++) chk("drain_order", 32'(got[i]), 32'(i + 1));

        // Wrap-around streaming with out_ready toggling.
        step(1, 0, '0, 0);
        sent.delete(); got.delete();
        for (int c = 0; c < 200 && sent.size() < 20; c++) begin
            logic [DW-1:0] w;
            bit o;
            w = DW'($urandom);
            o = (c % 2) == 0;
            step(0, 1, w, o);
            if (s_rdy) sent.push_back(w);
            if (s_ov && o) got.push_back(s_od);
        end
        for (int c = 0; c < 20; c++) begin
            step(0, 0, '0, 1);
            if (s_ov) got.push_back(s_od);
        end
        chk("wrap_count", 32'(got.size()), 32'(sent.size()));
        chk("wrap_sent", 32'(sent.size()), 20);
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            chk("wrap_order", 32'(got[i]), 32'(sent[i]));

        // Stall stability while writes continue until full.
        step(1, 0, '0, 0);
        step(0, 1, 10'h011, 0);
        step(0, 1, 10'h022, 0);
        held = 10'h011;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, DW'(10'h030 + i), 0);
            chk("stall_valid", 32'(s_ov), 1);
            chk("stall_data", 32'(s_od), 32'(held));
            chk("stall_no_read", 32'(s_rd), 0);
        end
        step(0, 1, 10'h0AA, 0);
        chk("stall_full_occ", 32'(s_occ), 7);
        chk("stall_full_ready", 32'(s_rdy), 0);

        // Reset mid-operation with occ=4, then a fresh word.
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, DW'(i + 5), 0);
        step(0, 0, '0, 0);
        chk("pre_rst_occ", 32'(s_occ), 4);
        step(1, 0, '0, 0);
        step(0, 1, 10'h3FF, 1);
        chk("post_rst_occ", 32'(s_occ), 0);
        chk("post_rst_valid", 32'(s_ov), 0);
        chk("post_rst_addr_w", 32'(s_aw), 0);
        step(0, 0, '0, 1);
        chk("post_rst_read", 32'(s_rd), 1);
        chk("post_rst_addr_r", 32'(s_ar), 0);
        step(0, 0, '0, 1);
        chk("post_rst_out_valid", 32'(s_ov), 1);
        chk("post_rst_out_data", 32'(s_od), 32'h3FF);

        // Randomised traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            bit r;
            r = ($urandom % 200) == 0;
            step(r, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Stream-side FIFO controller directly upstream and downstream of the team's dual-port RAM (parameters MEM_SIZE, DATA_W; registered read; no reset).
- Accepts a valid/ready input stream and drives the RAM write port, including wrap-around for non-power-of-2 depth.
- Issues RAM reads and presents RAM dataout as a first-word-fall-through valid/ready output stream.
- Tracks occupancy for flow control.

Parameters:
- MEM_SIZE, 6: RAM depth in words; any value >= 2, not restricted to powers of 2.
- DATA_W, 10: word width.
- AF_LEVEL, 5: almost-full threshold, counted against occ. Used only with FIFO_ALMOST_FULL_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream word present.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  equals ram_dataout, routed straight through.
- ram_write  out  1  to RAM write.
- ram_datain  out  DATA_W  to RAM datain; equals in_data.
- ram_addr_w  out  $clog2(MEM_SIZE)  to RAM addr_w.
- ram_read  out  1  to RAM read.
- ram_addr_r  out  $clog2(MEM_SIZE)  to RAM addr_r.
- ram_dataout  in  DATA_W  from RAM dataout; registered, valid 1 cycle after ram_read.
- occ  out  $clog2(MEM_SIZE+2)  words held = ram_cnt + out_valid.
- almost_full  out  1  see Optional Feature.

Behaviour:
- State: wr_ptr, rd_ptr (0..MEM_SIZE-1), ram_cnt (0..MEM_SIZE), out_valid.
- Reset: all state 0 and almost_full=0, so in_ready=1, occ=0. Reset mid-operation discards all words; RAM contents are not cleared; stale ram_dataout is masked because out_valid=0.
- Write side:
  - in_ready = (ram_cnt < MEM_SIZE), combinational from registers; does not depend on in_valid.
  - ram_write = in_valid & in_ready, with ram_addr_w = wr_ptr.
  - On write, wr_ptr advances; MEM_SIZE-1 wraps to 0.
- Read side:
  - ram_read = (ram_cnt != 0) & (!out_valid | out_ready), with ram_addr_r = rd_ptr.
  - On read, rd_ptr advances with the same wrap rule.
- out_valid next-state:
  - 1 if ram_read was issued this cycle.
  - Else 0 if out_ready was high this cycle.
  - Else holds.
  - While stalled, ram_read=0, so the RAM holds dataout and out_data stays stable.
- ram_cnt next-state = ram_cnt + ram_write - ram_read. Simultaneous write and read leaves ram_cnt unchanged.
- Address collision: write and read never target the same address in one cycle. A read needs ram_cnt>0, a write needs ram_cnt<MEM_SIZE, and the pointers coincide only at 0 or MEM_SIZE.
- Latency:
  - Write at edge T gives ram_cnt=1 after T; ram_read is issued in the following cycle; out_valid=1 one cycle later. Empty-to-output is 2 cycles.
  - With out_ready held high, throughput is 1 word/cycle.
- Capacity is MEM_SIZE+1: MEM_SIZE words in RAM plus 1 in the RAM output register. occ is the maximum MEM_SIZE+1 in that state.
- Full: in_ready=0; in_data is ignored and no state changes.
- Empty: out_valid=0 and ram_read=0.
- Handshake rule: out_data/out_valid must not change while out_valid=1 & out_ready=0.

Optional Feature:
- Macro FIFO_ALMOST_FULL_EN.
- Defined: almost_full is a register updated each cycle to (next occ >= AF_LEVEL); reset value 0.
- Undefined: almost_full is tied to 0 and AF_LEVEL is unused.

Decomposition:
- Shared package ram_fifo_pkg holds:
  - localparams for address width ($clog2(MEM_SIZE)) and occ width.
  - function ptr_next(ptr, size) implementing increment-with-wrap.
- One sub-module: mod_ptr_counter (enable, wrap at MEM_SIZE-1, synchronous reset to 0), instantiated for wr_ptr and rd_ptr.

Test Plan:
- Reset then idle: occ=0, in_ready=1, out_valid=0, ram_write=ram_read=0 for 10 cycles.
- Single word 0x155 written at cycle 0, out_ready=1: ram_addr_w=0; ram_read with ram_addr_r=0 at cycle 1; out_valid=1 with out_data=0x155 at cycle 2; occ returns to 0 after cycle 2.
- out_ready=0, push 7 words 1..7: in_ready drops after the 7th accept; occ=7; 8th word is held off. Then out_ready=1: words pop 1..7 in order, one per cycle.
- Wrap-around: 20 streamed words with out_ready toggling 1,0,1,0: ram_addr_w sequence 0..5,0..5,...; output order equals input order; no loss or duplication.
- Stall stability: out_valid=1 with out_ready=0 for 5 cycles: out_data constant, ram_read=0, and writes continue until full.
- Reset asserted with occ=4: next cycle occ=0, out_valid=0, pointers 0. A new word 0x3FF then emerges 2 cycles after its write.
